// File: rtl/fifo_status_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_status_ctrl
//
// Status and flag stage for the synchronous FIFO. The stage takes the write
// and read pointers and the raw wen/ren requests. It returns full/empty to the
// pointer blocks, which use them to gate pointer increments. It also produces
// registered watermark flags, the occupancy level, a high-water mark and
// sticky error flags.
//
// Parameters
//   PTR_WIDTH  address bits; DEPTH = 2**PTR_WIDTH; pointers are PTR_WIDTH+1 bits
//   AF_THRESH  almost_full when level >= AF_THRESH (1..DEPTH)
//   AE_THRESH  almost_empty when level <= AE_THRESH (0..DEPTH-1)
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   wptr, rptr     write/read pointers, MSB is the wrap bit
//   wen, ren       raw write/read requests (also drive the pointer blocks)
//   clr_err        clears overflow/underflow
//   clr_hwm        reloads the high-water mark with the next level
//   full, empty    combinational from the pointers
//   level          combinational occupancy, 0..DEPTH
//   almost_full    registered, level >= AF_THRESH
//   almost_empty   registered, level <= AE_THRESH
//   hwm            registered maximum level since reset/clr_hwm
//   overflow       sticky: write requested while full
//   underflow      sticky: read requested while empty
//
// Handshake: wen/ren are requests, and full/empty act as their inverted
// ready. A write transfers on a rising edge only when wen=1 and full=0. A read
// transfers only when ren=1 and empty=0. A request made while the FIFO is not
// ready is dropped, not held, and it sets the matching sticky error flag.
// ---------------------------------------------------------------------------
module fifo_status_ctrl #(
  parameter int PTR_WIDTH = 4,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PTR_WIDTH:0] wptr,
  input  logic [PTR_WIDTH:0] rptr,
  input  logic               wen,
  input  logic               ren,
  input  logic               clr_err,
  input  logic               clr_hwm,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic               almost_empty,
  output logic [PTR_WIDTH:0] level,
  output logic [PTR_WIDTH:0] hwm,
  output logic               overflow,
  output logic               underflow
);

  localparam int PW = PTR_WIDTH + 1;

  // Thresholds are resized to the level width so that all comparisons are
  // unsigned and of equal width.
  localparam logic [PTR_WIDTH:0] AF_LVL = PW'(AF_THRESH);
  localparam logic [PTR_WIDTH:0] AE_LVL = PW'(AE_THRESH);

  logic               wr_ok;
  logic               rd_ok;
  logic [PTR_WIDTH:0] wr_inc;
  logic [PTR_WIDTH:0] rd_dec;
  logic [PTR_WIDTH:0] level_nxt;
  logic               ovf_set;
  logic               unf_set;

  // ---------------------------------------------------------------------
  // Combinational status from the pointers
  // ---------------------------------------------------------------------
  // When the address bits are equal, the wrap bit decides between empty
  // (same lap) and full (writer one lap ahead).
  always_comb begin
    empty = (wptr == rptr);
    full  = (wptr[PTR_WIDTH] != rptr[PTR_WIDTH]) &&
            (wptr[PTR_WIDTH-1:0] == rptr[PTR_WIDTH-1:0]);
    // Modulo 2**PW subtraction gives the correct distance across the
    // pointer wrap for any distance up to DEPTH.
    level = wptr - rptr;
  end

  // ---------------------------------------------------------------------
  // Accepted operations and the level after this edge
  // ---------------------------------------------------------------------
  // The pointer blocks advance on the same edge that these registers
  // update. Registering flags derived from level_nxt, not level, keeps
  // them aligned with the pointers and avoids a cycle of lag.
  always_comb begin
    wr_ok     = wen & ~full;
    rd_ok     = ren & ~empty;
    wr_inc    = {{PTR_WIDTH{1'b0}}, wr_ok};
    rd_dec    = {{PTR_WIDTH{1'b0}}, rd_ok};
    level_nxt = level + wr_inc - rd_dec;
    ovf_set   = wen & full;
    unf_set   = ren & empty;
  end

  // ---------------------------------------------------------------------
  // Watermark flags
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (level_nxt >= AF_LVL);
      almost_empty <= (level_nxt <= AE_LVL);
    end
  end

  // ---------------------------------------------------------------------
  // High-water mark
  // ---------------------------------------------------------------------
  // clr_hwm restarts tracking from the level after this edge, so an
  // operation accepted in the same cycle is already included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hwm <= '0;
    end else if (clr_hwm) begin
      hwm <= level_nxt;
    end else if (level_nxt > hwm) begin
      hwm <= level_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Sticky error flags
  // ---------------------------------------------------------------------
  // A set event takes priority over clr_err in the same cycle, so a
  // violation that coincides with the clear is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_set | (overflow  & ~clr_err);
      underflow <= unf_set | (underflow & ~clr_err);
    end
  end

endmodule

// File: tb/tb_fifo_status_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_status_ctrl
//
// Directed bench for fifo_status_ctrl with DEPTH=16, AF_THRESH=14 and
// AE_THRESH=2. A small pointer block in the bench advances wptr/rptr using
// the DUT's full/empty outputs as gates, in the same way as the real pointer
// blocks. Every expected value is a hand-computed constant.
// ---------------------------------------------------------------------------
module tb_fifo_status_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] wptr;
  logic [4:0] rptr;
  logic       wen;
  logic       ren;
  logic       clr_err;
  logic       clr_hwm;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] level;
  logic [4:0] hwm;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int errors = 0;

  fifo_status_ctrl #(
    .PTR_WIDTH(4),
    .AF_THRESH(14),
    .AE_THRESH(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wptr        (wptr),
    .rptr        (rptr),
    .wen         (wen),
    .ren         (ren),
    .clr_err     (clr_err),
    .clr_hwm     (clr_hwm),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .level       (level),
    .hwm         (hwm),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pointer blocks: each pointer advances only while the DUT reports that
  // the FIFO is ready for that operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= 5'd0;
      rptr <= 5'd0;
    end else begin
      if (wen && !full)  wptr <= wptr + 5'd1;
      if (ren && !empty) rptr <= rptr + 5'd1;
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver / checker tasks ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // One clock with the given request pattern. Inputs change #1 after the
  // rising edge, and outputs are sampled #1 after the following edge.
  task automatic step(input logic w, input logic r, input logic ce, input logic ch);
    wen = w; ren = r; clr_err = ce; clr_hwm = ch;
    @(posedge clk);
    #1;
    wen = 1'b0; ren = 1'b0; clr_err = 1'b0; clr_hwm = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic f, input logic e, input logic af,
                         input logic ae, input logic [4:0] lv, input logic [4:0] hw,
                         input logic ov, input logic un);
    chk({tag, ".full"},         full,         f);
    chk({tag, ".empty"},        empty,        e);
    chk({tag, ".almost_full"},  almost_full,  af);
    chk({tag, ".almost_empty"}, almost_empty, ae);
    chk({tag, ".level"},        level,        lv);
    chk({tag, ".hwm"},          hwm,          hw);
    chk({tag, ".overflow"},     overflow,     ov);
    chk({tag, ".underflow"},    underflow,    un);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; wen = 1'b0; ren = 1'b0; clr_err = 1'b0; clr_hwm = 1'b0;
    #12;
    chk_all("reset", 0, 1, 0, 1, 5'd0, 5'd0, 0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_all("idle", 0, 1, 0, 1, 5'd0, 5'd0, 0, 0);

    // Fill 16 writes from empty.
    for (int k = 1; k <= 16; k++) begin
      step(1, 0, 0, 0);
      chk($sformatf("fill%0d.level", k), level, 32'(k));
      chk($sformatf("fill%0d.hwm", k), hwm, 32'(k));
      chk($sformatf("fill%0d.almost_full", k), almost_full, (k >= 14) ? 32'd1 : 32'd0);
      chk($sformatf("fill%0d.almost_empty", k), almost_empty, (k <= 2) ? 32'd1 : 32'd0);
      chk($sformatf("fill%0d.full", k), full, (k == 16) ? 32'd1 : 32'd0);
      chk($sformatf("fill%0d.overflow", k), overflow, 32'd0);
    end
    chk_all("full16", 1, 0, 1, 0, 5'd16, 5'd16, 0, 0);

    // 17th write at full: refused, overflow sets.
    step(1, 0, 0, 0);
    chk("wr_at_full.wptr", wptr, 32'd16);
    chk_all("wr_at_full", 1, 0, 1, 0, 5'd16, 5'd16, 1, 0);

    // clr_err alone clears the flag.
    step(0, 0, 1, 0);
    chk("clr_err.overflow", overflow, 32'd0);

    // clr_err together with a write at full: the set wins.
    step(1, 0, 1, 0);
    chk("clr_and_set.overflow", overflow, 32'd1);
    chk("clr_and_set.wptr", wptr, 32'd16);
    step(0, 0, 1, 0);
    chk("clr_err2.overflow", overflow, 32'd0);

    // Write and read together at full: only the read is accepted.
    step(1, 1, 0, 0);
    chk_all("wr_rd_full", 0, 0, 1, 0, 5'd15, 5'd16, 1, 0);
    chk("wr_rd_full.wptr", wptr, 32'd16);
    chk("wr_rd_full.rptr", rptr, 32'd1);

    // Drain the FIFO to empty.
    for (int k = 1; k <= 15; k++) begin
      step(0, 1, 0, 0);
      chk($sformatf("drain%0d.level", k), level, 32'(15 - k));
      chk($sformatf("drain%0d.almost_full", k), almost_full, (15 - k >= 14) ? 32'd1 : 32'd0);
      chk($sformatf("drain%0d.almost_empty", k), almost_empty, (15 - k <= 2) ? 32'd1 : 32'd0);
    end
    chk_all("drained", 0, 1, 0, 1, 5'd0, 5'd16, 1, 0);

    // Read while empty: refused, underflow sets.
    step(0, 1, 0, 0);
    chk("rd_at_empty.rptr", rptr, 32'd16);
    chk_all("rd_at_empty", 0, 1, 0, 1, 5'd0, 5'd16, 1, 1);
    step(0, 0, 1, 0);
    chk("clr_err3.overflow", overflow, 32'd0);
    chk("clr_err3.underflow", underflow, 32'd0);

    // Write and read together at empty: only the write is accepted.
    step(1, 1, 0, 0);
    chk_all("wr_rd_empty", 0, 0, 0, 1, 5'd1, 5'd16, 0, 1);
    chk("wr_rd_empty.wptr", wptr, 32'd17);
    chk("wr_rd_empty.rptr", rptr, 32'd16);

    // Reset during a fill: takes effect without a clock edge.
    for (int k = 0; k < 4; k++) step(1, 0, 0, 0);
    chk("prefill.level", level, 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_reset", 0, 1, 0, 1, 5'd0, 5'd0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Build level 8, then read back to 5: hwm holds at 8.
    for (int k = 0; k < 8; k++) step(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 1, 0, 0);
    chk_all("level5", 0, 0, 0, 0, 5'd5, 5'd8, 0, 0);

    // 40 interleaved write/read pairs cross the pointer MSB wrap.
    for (int k = 1; k <= 40; k++) begin
      step(1, 1, 0, 0);
      chk_all($sformatf("wrap%0d", k), 0, 0, 0, 0, 5'd5, 5'd8, 0, 0);
    end
    chk("wrap.wptr", wptr, 32'd16);
    chk("wrap.rptr", rptr, 32'd11);

    // clr_hwm reloads the mark with the current level.
    step(0, 0, 0, 1);
    chk("clr_hwm.hwm", hwm, 32'd5);
    step(1, 0, 0, 0);
    chk("hwm_after_clr.hwm", hwm, 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
